control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle instruction control FSM: fetch/decode/execute/memory/writeback/halt.
// Define CONTROL_SEQUENCER_BLT_EN to let opcode 0111 branch on LT_flag; otherwise it retires as a NOP.
module control_sequencer #(
  parameter int OP_W  = 4,
  parameter int ALU_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             control_reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic             mem_ready,
  input  logic             branch_flag,
  input  logic             LT_flag,
  output logic [2:0]       state,
  output logic [OP_W-1:0]  opcode_store,
  output logic [ALU_W-1:0] alu_control,
  output logic             PC_EN,
  output logic             ten_branch,
  output logic             read_1EN,
  output logic             read_2EN,
  output logic             EN_mem_add,
  output logic             RAM_wrEN,
  output logic             reg_file_wrEN,
  output logic             write_reg_from_memory,
  output logic             EN_output,
  output logic             PC_reset,
  output logic             reset_reg_file,
  output logic             mem_add_reset,
  output logic             output_reset,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

`ifdef CONTROL_SEQUENCER_BLT_EN
  localparam logic BLT_EN = 1'b1;
`else
  localparam logic BLT_EN = 1'b0;
`endif

  state_t cur_state, nxt_state;
  logic   retire;

  logic [3:0] op_lo;
  logic upper_bad, is_nop, is_alu, is_load, is_store, is_beq, is_blt, is_out, is_halt, is_illegal;
  logic take_branch;

  assign state     = cur_state;
  assign op_lo     = opcode_store[3:0];
  assign upper_bad = |(opcode_store >> 4);
  assign is_nop    = !upper_bad && op_lo == 4'h0;
  assign is_alu    = !upper_bad && (op_lo == 4'h1 || op_lo == 4'h2 || op_lo == 4'h3);
  assign is_load   = !upper_bad && op_lo == 4'h4;
  assign is_store  = !upper_bad && op_lo == 4'h5;
  assign is_beq    = !upper_bad && op_lo == 4'h6;
  assign is_blt    = !upper_bad && op_lo == 4'h7;
  assign is_out    = !upper_bad && op_lo == 4'h8;
  assign is_halt   = !upper_bad && op_lo == 4'hF;
  assign is_illegal = !(is_nop || is_alu || is_load || is_store || is_beq ||
                        is_blt || is_out || is_halt);
  assign take_branch = (is_beq && branch_flag) || (BLT_EN && is_blt && LT_flag);

  always_comb begin
    nxt_state = cur_state;
    retire    = 1'b0;
    case (cur_state)
      S_FETCH:  if (mem_ready) nxt_state = S_DECODE;
      S_DECODE: begin
        if (is_halt || is_illegal) begin
          nxt_state = S_HALT;
        end else if (is_nop || (is_blt && !BLT_EN)) begin
          nxt_state = S_FETCH;
          retire    = 1'b1;
        end else begin
          nxt_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_alu) begin
          nxt_state = S_WB;
        end else if (is_load || is_store) begin
          nxt_state = S_MEM;
        end else begin
          nxt_state = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_MEM: begin
        if (is_store) begin
          nxt_state = S_FETCH;
          retire    = 1'b1;
        end else if (mem_ready) begin
          nxt_state = S_WB;
        end
      end
      S_WB: begin
        nxt_state = S_FETCH;
        retire    = 1'b1;
      end
      S_HALT:  nxt_state = S_HALT;
      default: nxt_state = S_FETCH;
    endcase
  end

  // Datapath controls are decoded directly from the current state so they line up with it.
  always_comb begin
    alu_control           = '0;
    PC_EN                 = 1'b0;
    ten_branch            = 1'b0;
    read_1EN              = 1'b0;
    read_2EN              = 1'b0;
    EN_mem_add            = 1'b0;
    RAM_wrEN              = 1'b0;
    reg_file_wrEN         = 1'b0;
    write_reg_from_memory = 1'b0;
    EN_output             = 1'b0;
    halted                = 1'b0;
    PC_reset              = control_reset;
    reset_reg_file        = control_reset;
    mem_add_reset         = control_reset;
    output_reset          = control_reset;
    if (!control_reset) begin
      case (cur_state)
        S_FETCH:  PC_EN = mem_ready;
        S_DECODE: begin
          read_1EN = 1'b1;
          read_2EN = 1'b1;
        end
        S_EXEC: begin
          if (is_alu && op_lo == 4'h2) alu_control = ALU_W'(1);
          if (is_alu && op_lo == 4'h3) alu_control = ALU_W'(2);
          EN_mem_add = is_load || is_store;
          EN_output  = is_out;
          PC_EN      = take_branch;
          ten_branch = take_branch;
        end
        S_MEM: RAM_wrEN = is_store;
        S_WB: begin
          reg_file_wrEN         = 1'b1;
          write_reg_from_memory = is_load;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (control_reset) begin
      cur_state     <= S_FETCH;
      opcode_store  <= '0;
      retired_count <= '0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_FETCH && mem_ready) opcode_store <= opcode;
      if (retire && retired_count != '1) retired_count <= retired_count + CNT_W'(1);
    end
  end

endmodule
